// File: rtl/instr_encoder.sv
// Packs MIPS R/I/J instruction fields into 32-bit words and streams them with byte addresses.
// Optional macro ENC_FIELD_CHECK_EN adds opcode legality checks per format.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  fmt,
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  func,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic [15:0] count,
   output logic        full,
   output logic        err
);

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_J   = 2'd2,
      FMT_BAD = 2'd3
   } fmt_e;

   localparam logic [5:0]  OP_SPECIAL = 6'h00;
   localparam logic [5:0]  OP_J       = 6'h02;
   localparam logic [5:0]  OP_JAL     = 6'h03;
   localparam logic [15:0] DEPTH_W    = DEPTH[15:0];

`ifdef ENC_FIELD_CHECK_EN
   localparam bit FIELD_CHECK = 1'b1;
`else
   localparam bit FIELD_CHECK = 1'b0;
`endif

   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] addr_q;
   logic [31:0] next_addr_q;
   logic [15:0] count_q;
   logic        full_q;
   logic        err_q;

   logic [31:0] word_d;
   logic        legal_d;
   logic        take;
   logic        drain;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      word_d  = '0;
      legal_d = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: begin
            word_d  = {op, rs, rt, rd, shamt, func};
            legal_d = !FIELD_CHECK || (op == OP_SPECIAL);
         end
         FMT_I: begin
            word_d  = {op, rs, rt, imm};
            legal_d = !FIELD_CHECK ||
                      !((op == OP_SPECIAL) || (op == OP_J) || (op == OP_JAL));
         end
         FMT_J: begin
            word_d  = {op, target};
            legal_d = !FIELD_CHECK || (op == OP_J) || (op == OP_JAL);
         end
         default: begin
            word_d  = '0;
            legal_d = 1'b0;
         end
      endcase
   end

   // The output slot may be refilled in the same cycle it drains, giving one word per cycle.
   assign in_ready = !full_q && (!valid_q || out_ready);
   assign take     = in_valid && in_ready;
   assign drain    = valid_q && out_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         instr_q     <= '0;
         addr_q      <= BASE_ADDR;
         next_addr_q <= BASE_ADDR;
         count_q     <= '0;
         full_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (drain) begin
            valid_q <= 1'b0;
         end
         if (take && legal_d) begin
            valid_q     <= 1'b1;
            instr_q     <= word_d;
            addr_q      <= next_addr_q;
            next_addr_q <= next_addr_q + 32'd4;
            count_q     <= count_q + 16'd1;
            full_q      <= ((count_q + 16'd1) == DEPTH_W);
         end
         // Rejected bundles are dropped; only the sticky error records them.
         if (take && !legal_d) begin
            err_q <= 1'b1;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign count     = count_q;
   assign full      = full_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// against a queue-based scoreboard; a second DEPTH=2 instance covers the full limit.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam int          MAIN_DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [1:0]  fmt;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [25:0] target;
   logic        out_ready;

   logic        in_ready, out_valid, full, err;
   logic [31:0] out_instr, out_addr;
   logic [15:0] count;

   logic        s_in_ready, s_out_valid, s_full, s_err;
   logic [31:0] s_out_instr, s_out_addr;
   logic [15:0] s_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Scoreboard: words accepted but not yet taken by the consumer, plus totals.
   logic [31:0] exp_q[$];
   int          m_count;
   bit          m_err;

   always #5 clk = ~clk;

   instr_encoder #(.BASE_ADDR(BASE), .DEPTH(MAIN_DEPTH)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
      .imm(imm), .target(target), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .count(count), .full(full), .err(err)
   );

   instr_encoder #(.BASE_ADDR(BASE), .DEPTH(2)) u_small (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
      .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
      .imm(imm), .target(target), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_instr(s_out_instr), .out_addr(s_out_addr), .count(s_count), .full(s_full),
      .err(s_err)
   );

   function automatic logic [31:0] ref_word(input logic [1:0] f, input logic [5:0] o,
         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
         input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
      int unsigned w;
      case (f)
         2'd0: w = o * 2**26 + a * 2**21 + b * 2**16 + c * 2**11 + sh * 2**6 + fn;
         2'd1: w = o * 2**26 + a * 2**21 + b * 2**16 + im;
         2'd2: w = o * 2**26 + tg;
         default: w = 0;
      endcase
      return w;
   endfunction

   function automatic bit ref_legal(input logic [1:0] f, input logic [5:0] o);
      if (f == 2'd3) return 1'b0;
`ifdef ENC_FIELD_CHECK_EN
      if (f == 2'd0) return o == 6'h00;
      if (f == 2'd2) return (o == 6'h02) || (o == 6'h03);
      return !((o == 6'h00) || (o == 6'h02) || (o == 6'h03));
`else
      return 1'b1;
`endif
   endfunction

   task automatic drive(input logic v, input logic [1:0] f, input logic [5:0] o,
         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
         input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
      in_valid = v; fmt = f; op = o; rs = a; rt = b; rd = c; shamt = sh;
      func = fn; imm = im; target = tg;
   endtask

   // Advances one clock; the scoreboard follows the main instance's handshake rules.
   task automatic tick();
      bit is_full, rdy, take, drain, legal;
      logic [31:0] w;
      is_full = (m_count == MAIN_DEPTH);
      rdy     = !is_full && (exp_q.size() == 0 || out_ready);
      take    = in_valid && rdy;
      drain   = (exp_q.size() != 0) && out_ready;
      legal   = ref_legal(fmt, op);
      w       = ref_word(fmt, op, rs, rt, rd, shamt, func, imm, target);
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         m_count = 0;
         m_err   = 1'b0;
      end else begin
         if (drain) void'(exp_q.pop_front());
         if (take && legal) begin
            exp_q.push_back(w);
            m_count++;
         end
         if (take && !legal) m_err = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      out_ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
      n_cmp++; if (out_addr !== BASE) begin n_bad++; $display("FAIL reset_addr: got %h want %h", out_addr, BASE); end
      n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (full !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got full=%b err=%b want 0 0", full, err); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_addu();
      do_reset();
      drive(1'b1, 2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hFFFF, 26'h3FF_FFFF);
      tick();
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addu_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_instr !== 32'h0022_1821) begin n_bad++; $display("FAIL addu_instr: got %h want 00221821", out_instr); end
      n_cmp++; if (out_addr !== 32'h3000) begin n_bad++; $display("FAIL addu_addr: got %h want 3000", out_addr); end
      n_cmp++; if (count !== 16'd1) begin n_bad++; $display("FAIL addu_count: got %0d want 1", count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, 2'd1, 6'h0D, 5'd0, 5'd1, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h0);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
      tick();
      drive(1'b1, 2'd2, 6'h03, 5'd9, 5'd9, 5'd9, 5'd9, 6'h9, 16'h9999, 26'h0000C03);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
      n_cmp++; if (out_instr !== 32'h3401_1234 || out_addr !== 32'h3000) begin n_bad++; $display("FAIL b2b_ori: got %h@%h want 34011234@3000", out_instr, out_addr); end
      tick();
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h0C00_0C03 || out_addr !== 32'h3004) begin n_bad++; $display("FAIL b2b_jal: got v=%b %h@%h want 1 0c000c03@3004", out_valid, out_instr, out_addr); end
   endtask

   task automatic test_backpressure();
      logic [31:0] word_b;
      do_reset();
      drive(1'b1, 2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd2, 6'h20, 16'h0, 26'h0);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 2'd1, 6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'hBEEF, 26'h0);
      word_b = 32'h2064_BEEF;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h0085_30A0 || out_addr !== 32'h3000)
            begin n_bad++; $display("FAIL stall_%0d: got rdy=%b v=%b %h@%h want 0 1 008530a0@3000", i, in_ready, out_valid, out_instr, out_addr); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
      tick();
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== word_b || out_addr !== 32'h3004 || count !== 16'd2)
         begin n_bad++; $display("FAIL stall_next: got v=%b %h@%h cnt=%0d want 1 %h@3004 cnt=2", out_valid, out_instr, out_addr, count, word_b); end
   endtask

   task automatic test_illegal();
      do_reset();
      drive(1'b1, 2'd1, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
      tick();
      #1;
      n_cmp++; if (out_addr !== 32'h3000 || err !== 1'b0) begin n_bad++; $display("FAIL ill_first: got addr=%h err=%b want 3000 0", out_addr, err); end
      drive(1'b1, 2'd3, 6'h0D, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
      tick();
      #1;
      n_cmp++; if (err !== 1'b1 || out_valid !== 1'b0 || count !== 16'd1) begin n_bad++; $display("FAIL ill_drop: got err=%b v=%b cnt=%0d want 1 0 1", err, out_valid, count); end
      drive(1'b1, 2'd1, 6'h0D, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0);
      tick();
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      #1;
      n_cmp++; if (out_instr !== 32'h3402_0002 || out_addr !== 32'h3004 || count !== 16'd2 || err !== 1'b1)
         begin n_bad++; $display("FAIL ill_second: got %h@%h cnt=%0d err=%b want 34020002@3004 2 1", out_instr, out_addr, count, err); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'(i + 1));
         #1;
         n_cmp++; if (s_in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_%0d: got %b want 1", i, s_in_ready); end
         tick();
      end
      out_ready = 1'b0;
      drive(1'b1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd3);
      #1;
      n_cmp++; if (s_full !== 1'b1 || s_count !== 16'd2 || s_in_ready !== 1'b0) begin n_bad++; $display("FAIL full_flag: got full=%b cnt=%0d rdy=%b want 1 2 0", s_full, s_count, s_in_ready); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (s_in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_drain: got %b want 0", s_in_ready); end
      out_ready = 1'b0;
      tick();
      tick();
      #1;
      n_cmp++; if (s_count !== 16'd2 || s_out_valid !== 1'b1 || s_out_instr !== 32'h0800_0002 || s_out_addr !== 32'h3004)
         begin n_bad++; $display("FAIL full_hold: got cnt=%0d v=%b %h@%h want 2 1 08000002@3004", s_count, s_out_valid, s_out_instr, s_out_addr); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (s_out_valid !== 1'b0 || s_count !== 16'd0 || s_out_addr !== 32'h3000 || s_full !== 1'b0)
         begin n_bad++; $display("FAIL full_reset: got v=%b cnt=%0d addr=%h full=%b want 0 0 3000 0", s_out_valid, s_count, s_out_addr, s_full); end
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
   endtask

   task automatic test_field_check();
      do_reset();
      drive(1'b1, 2'd0, 6'h0D, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0);
      tick();
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      #1;
`ifdef ENC_FIELD_CHECK_EN
      n_cmp++; if (out_valid !== 1'b0 || err !== 1'b1 || count !== 16'd0) begin n_bad++; $display("FAIL fchk_drop: got v=%b err=%b cnt=%0d want 0 1 0", out_valid, err, count); end
`else
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h3422_1821 || err !== 1'b0) begin n_bad++; $display("FAIL fchk_verbatim: got v=%b %h err=%b want 1 34221821 0", out_valid, out_instr, err); end
`endif
   endtask

   task automatic test_random();
      int unsigned head_idx;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         reset = ($urandom_range(0, 79) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom()),
               5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
               6'($urandom()), 16'($urandom()), 26'($urandom()));
         if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 3));
         #1;
         n_cmp++;
         if (out_valid !== (exp_q.size() != 0) || count !== 16'(m_count) || err !== m_err ||
             in_ready !== ((m_count != MAIN_DEPTH) && (exp_q.size() == 0 || out_ready)))
            begin n_bad++; $display("FAIL rnd_state_%0d: got v=%b cnt=%0d err=%b rdy=%b want v=%0d cnt=%0d err=%b", cyc, out_valid, count, err, in_ready, exp_q.size(), m_count, m_err); end
         if (exp_q.size() != 0) begin
            head_idx = m_count - exp_q.size();
            n_cmp++;
            if (out_instr !== exp_q[0] || out_addr !== BASE + 4 * head_idx)
               begin n_bad++; $display("FAIL rnd_word_%0d: got %h@%h want %h@%h", cyc, out_instr, out_addr, exp_q[0], BASE + 4 * head_idx); end
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      m_count = 0;
      m_err = 1'b0;
      @(negedge clk);
      test_reset();
      test_addu();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_full();
      test_field_check();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
